// File: rtl/store_buffer_if.sv
// Store-buffer port bundle: M-stage store/load side, drain side toward data memory and status.
// The slave modport is the buffer itself; the master modport is the pipeline/memory environment.
interface store_buffer_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16
);
   logic              mem_write_m;
   logic [ADDR_W-1:0] data_address_m;
   logic [DATA_W-1:0] store_data_m;
   logic              mem_read_m;
   logic [ADDR_W-1:0] load_address_m;
   logic              stall_m;
   logic              fwd_hit_m;
   logic [DATA_W-1:0] fwd_data_m;
   logic              mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_ack;
   logic              empty;
   logic [CNT_W-1:0]  drained_count;

   modport slave (
      input  mem_write_m, data_address_m, store_data_m,
      input  mem_read_m, load_address_m, mem_ack,
      output stall_m, fwd_hit_m, fwd_data_m,
      output mem_req, mem_addr, mem_wdata, empty, drained_count
   );

   modport master (
      output mem_write_m, data_address_m, store_data_m,
      output mem_read_m, load_address_m, mem_ack,
      input  stall_m, fwd_hit_m, fwd_data_m,
      input  mem_req, mem_addr, mem_wdata, empty, drained_count
   );
endinterface

// File: rtl/store_buffer.sv
// Posted-write buffer: in-order FIFO of M-stage stores drained to memory over req/ack,
// with youngest-match store-to-load forwarding on word addresses.
module store_buffer #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic          clk,
   input  logic          reset,
   store_buffer_if.slave bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int OCC_W = PTR_W + 1;

   typedef enum logic [1:0] {
      S_EMPTY,
      S_ACTIVE,
      S_FULL
   } state_t;

   state_t            r_state;
   state_t            w_state_next;
   logic [OCC_W-1:0]  r_count;
   logic [OCC_W-1:0]  w_count_next;
   logic [PTR_W-1:0]  r_wptr;
   logic [PTR_W-1:0]  r_rptr;
   logic [CNT_W-1:0]  r_drained;
   logic [ADDR_W-1:0] r_addr [DEPTH];
   logic [DATA_W-1:0] r_data [DEPTH];

   logic              w_empty;
   logic              w_full;
   logic              w_push;
   logic              w_pop;
   logic              w_fwd_hit;
   logic [DATA_W-1:0] w_fwd_data;
   logic [PTR_W-1:0]  w_idx;
   logic              w_unused_lsb;

   assign w_empty = (r_state == S_EMPTY);
   assign w_full  = (r_state == S_FULL);
   assign w_push  = bus.mem_write_m & ~w_full;
   assign w_pop   = ~w_empty & bus.mem_ack;

   // Byte offset within the word plays no part in forwarding.
   assign w_unused_lsb = ^bus.load_address_m[1:0];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= S_EMPTY;
         r_count   <= '0;
         r_wptr    <= '0;
         r_rptr    <= '0;
         r_drained <= '0;
      end else begin
         r_state <= w_state_next;
         r_count <= w_count_next;
         if (w_push) r_wptr <= r_wptr + PTR_W'(1);
         if (w_pop) begin
            r_rptr    <= r_rptr + PTR_W'(1);
            r_drained <= r_drained + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_addr[r_wptr] <= bus.data_address_m;
         r_data[r_wptr] <= bus.store_data_m;
      end
   end

   always_comb begin
      w_count_next = r_count;
      w_state_next = r_state;
      case ({w_push, w_pop})
         2'b10:   w_count_next = r_count + OCC_W'(1);
         2'b01:   w_count_next = r_count - OCC_W'(1);
         default: w_count_next = r_count;
      endcase
      if (w_count_next == '0)
         w_state_next = S_EMPTY;
      else if (w_count_next == OCC_W'(DEPTH))
         w_state_next = S_FULL;
      else
         w_state_next = S_ACTIVE;
   end

   // Walk oldest to youngest so the last match seen is the youngest store.
   always_comb begin
      w_fwd_hit  = 1'b0;
      w_fwd_data = '0;
      w_idx      = '0;
      for (int k = 0; k < DEPTH; k++) begin
         w_idx = r_rptr + PTR_W'(k);
         if ((OCC_W'(k) < r_count) &&
             (r_addr[w_idx][ADDR_W-1:2] == bus.load_address_m[ADDR_W-1:2])) begin
            w_fwd_hit  = 1'b1;
            w_fwd_data = r_data[w_idx];
         end
      end
   end

   assign bus.stall_m       = bus.mem_write_m & w_full;
   assign bus.fwd_hit_m     = bus.mem_read_m & w_fwd_hit;
   assign bus.fwd_data_m    = (bus.mem_read_m & w_fwd_hit) ? w_fwd_data : '0;
   assign bus.mem_req       = ~w_empty;
   assign bus.mem_addr      = w_empty ? '0 : r_addr[r_rptr];
   assign bus.mem_wdata     = w_empty ? '0 : r_data[r_rptr];
   assign bus.empty         = w_empty;
   assign bus.drained_count = r_drained;
endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: drain latency, full stall, forwarding, streaming,
// ack back-pressure ordering and asynchronous reset mid-drain.
module tb_store_buffer;
   logic clk;
   logic reset;
   int   checks;
   int   errors;

   store_buffer_if #(.ADDR_W(32), .DATA_W(32), .CNT_W(16)) bus ();

   store_buffer #(.DEPTH(4), .ADDR_W(32), .DATA_W(32), .CNT_W(16)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic store(input logic [31:0] a, input logic [31:0] d);
      bus.mem_write_m    = 1'b1;
      bus.data_address_m = a;
      bus.store_data_m   = d;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int head;
      logic ack_pat [7];
      checks = 0;
      errors = 0;
      reset  = 1'b0;
      bus.mem_write_m    = 1'b0;
      bus.data_address_m = '0;
      bus.store_data_m   = '0;
      bus.mem_read_m     = 1'b0;
      bus.load_address_m = '0;
      bus.mem_ack        = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("rst_req",     bus.mem_req, 0);
      chk("rst_empty",   bus.empty, 1);
      chk("rst_stall",   bus.stall_m, 0);
      chk("rst_hit",     bus.fwd_hit_m, 0);
      chk("rst_drained", bus.drained_count, 0);
      chk("rst_addr",    bus.mem_addr, 0);
      chk("rst_wdata",   bus.mem_wdata, 0);
      chk("rst_fwd",     bus.fwd_data_m, 0);
      reset = 1'b1;
      step();

      // Single store with ack tied high
      bus.mem_ack = 1'b1;
      store(100, 25);
      chk("t1_stall", bus.stall_m, 0);
      chk("t1_noreq", bus.mem_req, 0);
      step();
      bus.mem_write_m = 1'b0;
      chk("t1_req",   bus.mem_req, 1);
      chk("t1_addr",  bus.mem_addr, 100);
      chk("t1_wdata", bus.mem_wdata, 25);
      step();
      chk("t1_drained", bus.drained_count, 1);
      chk("t1_empty",   bus.empty, 1);
      chk("t1_req0",    bus.mem_req, 0);

      // Fill to full, stall on fifth, then drain in order
      bus.mem_ack = 1'b0;
      for (int i = 0; i < 4; i++) begin
         store(96 + 4 * i, 1000 + i);
         chk("t2_fill_stall", bus.stall_m, 0);
         step();
      end
      store(112, 1004);
      chk("t2_stall5", bus.stall_m, 1);
      chk("t2_head",   bus.mem_addr, 96);
      step();
      chk("t2_stall_held", bus.stall_m, 1);
      chk("t2_head_held",  bus.mem_addr, 96);
      bus.mem_ack = 1'b1;
      chk("t2_stall_ack", bus.stall_m, 1);
      step();
      chk("t2_stall_after_pop", bus.stall_m, 0);
      chk("t2_addr100", bus.mem_addr, 100);
      chk("t2_drn2",    bus.drained_count, 2);
      step();
      bus.mem_write_m = 1'b0;
      chk("t2_addr104", bus.mem_addr, 104);
      chk("t2_drn3",    bus.drained_count, 3);
      step();
      chk("t2_addr108", bus.mem_addr, 108);
      step();
      chk("t2_addr112",  bus.mem_addr, 112);
      chk("t2_wdata112", bus.mem_wdata, 1004);
      step();
      chk("t2_empty", bus.empty, 1);
      chk("t2_drn6",  bus.drained_count, 6);

      // Forwarding: youngest same-word store wins
      bus.mem_ack = 1'b0;
      store(100, 7);
      step();
      store(100, 25);
      step();
      bus.mem_write_m    = 1'b0;
      bus.mem_read_m     = 1'b1;
      bus.load_address_m = 102;
      #1;
      chk("t3_hit",  bus.fwd_hit_m, 1);
      chk("t3_data", bus.fwd_data_m, 25);
      bus.load_address_m = 200;
      #1;
      chk("t3_miss",      bus.fwd_hit_m, 0);
      chk("t3_miss_data", bus.fwd_data_m, 0);
      bus.mem_read_m     = 1'b0;
      bus.load_address_m = 100;
      #1;
      chk("t3_noread", bus.fwd_hit_m, 0);
      bus.mem_read_m = 1'b1;
      bus.mem_ack    = 1'b1;
      step();
      chk("t3_hit_one",  bus.fwd_hit_m, 1);
      chk("t3_data_one", bus.fwd_data_m, 25);
      step();
      chk("t3_hit_gone", bus.fwd_hit_m, 0);
      chk("t3_drn8",     bus.drained_count, 8);
      bus.mem_read_m = 1'b0;

      // Streaming with ack held high: one in, one out each cycle
      store(32'h200, 32'h50);
      step();
      for (int k = 1; k < 8; k++) begin
         chk("t4_req",   bus.mem_req, 1);
         chk("t4_addr",  bus.mem_addr, 32'h200 + 4 * (k - 1));
         chk("t4_stall", bus.stall_m, 0);
         store(32'h200 + 4 * k, 32'h50 + k);
         step();
      end
      bus.mem_write_m = 1'b0;
      chk("t4_last", bus.mem_addr, 32'h21C);
      step();
      chk("t4_drn16", bus.drained_count, 16);
      chk("t4_empty", bus.empty, 1);

      // Ack back-pressure: head stable while not acked, order preserved
      bus.mem_ack = 1'b0;
      for (int i = 0; i < 3; i++) begin
         store(32'h300 + 4 * i, 32'hA0 + i);
         step();
      end
      bus.mem_write_m = 1'b0;
      ack_pat = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      head = 0;
      for (int c = 0; c < 7; c++) begin
         bus.mem_ack = ack_pat[c];
         chk("t5_addr",  bus.mem_addr, 32'h300 + 4 * head);
         chk("t5_wdata", bus.mem_wdata, 32'hA0 + head);
         step();
         if (ack_pat[c]) head++;
      end
      chk("t5_empty", bus.empty, 1);
      chk("t5_drn19", bus.drained_count, 19);

      // Asynchronous reset mid-drain with three entries
      bus.mem_ack = 1'b0;
      for (int i = 0; i < 3; i++) begin
         store(32'h400 + 4 * i, 32'hB0 + i);
         step();
      end
      bus.mem_write_m = 1'b0;
      chk("t6_req_pre", bus.mem_req, 1);
      #2 reset = 1'b0;
      #1;
      chk("t6_req_async", bus.mem_req, 0);
      chk("t6_empty",     bus.empty, 1);
      chk("t6_drn0",      bus.drained_count, 0);
      @(negedge clk);
      reset       = 1'b1;
      bus.mem_ack = 1'b1;
      step();
      step();
      chk("t6_no_stale_req", bus.mem_req, 0);
      chk("t6_no_stale_drn", bus.drained_count, 0);
      chk("t6_empty_after",  bus.empty, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/store_buffer.md
# store_buffer

Posted-write buffer between the memory stage of `processor_top` and the data memory. It captures every store issued by the M stage (`mem_write_m`, `data_address_m`, `store_data_m`) into a small in-order FIFO. It drains stored entries to data memory over a req/ack handshake, and it stalls M only when the buffer is full. Loads in M check the buffer for a matching word address and receive forwarded store data, so the pipeline sees memory as if stores had completed immediately.

## Interface
- `DEPTH`, 4: number of entries; a power of two, ≥2.
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: store data width.
- `CNT_W`, 16: width of the drained-store counter.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `mem_write_m`  in  1  M-stage store valid.
- `data_address_m`  in  ADDR_W  store byte address.
- `store_data_m`  in  DATA_W  store data, full word.
- `mem_read_m`  in  1  M-stage load valid.
- `load_address_m`  in  ADDR_W  load byte address.
- `stall_m`  out  1  hold the M stage; the store is not accepted this cycle.
- `fwd_hit_m`  out  1  load word address matches a buffered store.
- `fwd_data_m`  out  DATA_W  data of the youngest matching entry.
- `mem_req`  out  1  drain request to data memory.
- `mem_addr`  out  ADDR_W  address of the head entry.
- `mem_wdata`  out  DATA_W  data of the head entry.
- `mem_ack`  in  1  memory accepted the head entry at this edge.
- `empty`  out  1  no valid entries.
- `drained_count`  out  CNT_W  number of completed drains.

## Operation
- Storage is a circular FIFO with `DEPTH` entries, read and write pointers, and an occupancy count of `$clog2(DEPTH)+1` bits.
- Occupancy states:
  - EMPTY: count = 0.
  - ACTIVE: 0 < count < DEPTH.
  - FULL: count = DEPTH.
  - Transitions are driven by push/pop; push and pop together leave the count unchanged.
- Push = `mem_write_m & ~full`. The write pointer increments modulo DEPTH and wraps naturally.
- `stall_m` = `mem_write_m & full`, combinational. It does not depend on `mem_ack`; there is no same-cycle full bypass.
- Pop = `mem_req & mem_ack`. The read pointer increments modulo DEPTH, and `drained_count` increments, wrapping at 2^CNT_W.
- `mem_req` = `~empty`.
  - `mem_addr` and `mem_wdata` present the head entry.
  - These outputs stay stable while `mem_req & ~mem_ack`.
  - `mem_ack` without `mem_req` is ignored.
- Forwarding is combinational.
  - Compare `load_address_m[ADDR_W-1:2]` against every valid entry.
  - On multiple hits, the youngest entry (closest to the write pointer) wins.
  - `fwd_hit_m` = 0 when `mem_read_m` = 0.
  - An entry popping in the current cycle still forwards in that cycle.
  - A store pushed in the current cycle does not forward until the next cycle. Load and store cannot coexist in M.
- Entries are drained in strict program order. Same-address stores are not merged.

## Timing
- Reset (asynchronous, `reset` = 0):
  - Count and pointers are cleared; all entries are invalid.
  - `mem_req` = 0, `empty` = 1, `stall_m` = 0 unless the full term applies (it does not after reset), `fwd_hit_m` = 0, `drained_count` = 0.
  - `mem_addr`, `mem_wdata` and `fwd_data_m` read 0.
  - Reset during an outstanding request drops the request immediately; the entry is discarded.
- Store-to-request latency: a store accepted at edge N produces `mem_req` = 1 after edge N, provided the buffer was empty.
- Pop occurs at the edge where `mem_req & mem_ack` = 1. The next entry, if any, is presented in the following cycle with no bubble.
- Sustained throughput is 1 push and 1 pop per cycle.
- Full with `mem_ack` = 1:
  - The pop happens at that edge, and `stall_m` was 1 during that cycle.
  - The stalled store is accepted in the next cycle.
- Empty with a push in the same cycle: no pop. The ack is ignored because `mem_req` = 0.
- Counter: `drained_count` wraps from 2^CNT_W−1 to 0.

## Test plan
- Single store to 100 with data 25, `mem_ack` tied to 1 → `mem_req` one cycle later with `mem_addr` = 100 and `mem_wdata` = 25; popped at that edge; `drained_count` = 1; `empty` = 1.
- `mem_ack` = 0, five consecutive stores to 96, 100, 104, 108, 112 (DEPTH = 4) → `stall_m` = 1 on the fifth. Then raise `mem_ack` → drains in order 96, 100, 104, 108, 112, and the fifth is accepted the cycle after the first pop.
- Stores to 100 (data 7) then 100 (data 25), undrained; load from 102 → `fwd_hit_m` = 1 with `fwd_data_m` = 25. Load from 200 → `fwd_hit_m` = 0.
- Back-to-back stores with `mem_ack` held at 1 for 8 cycles → count stays at 1, `stall_m` never asserts, pointers wrap twice, `drained_count` = 8.
- Random `mem_ack` stalls → `mem_addr` and `mem_wdata` are stable across each stalled cycle; drain order matches push order.
- Assert `reset` = 0 mid-drain with 3 entries → `mem_req` drops asynchronously, `empty` = 1, `drained_count` = 0; after release, no stale drains occur.
